ts_envelope_scheduler: RTL and testbench



---
 rtl/ts_envelope_scheduler_pkg.sv | 40 ++++
 rtl/ts_envelope_scheduler_envelope_pair.sv | 60 ++++++
 rtl/ts_envelope_scheduler.sv | 168 ++++++++++++++++
 tb/tb_ts_envelope_scheduler.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ts_envelope_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// ts_pkg
// Shared types and constants for the transient shaper envelope scheduler.
//   phase_t     : gain schedule state, encoding is visible on the phase port
//   gain_t      : Q2.6 gain coefficient (64 = unity)
//   ENV_W       : envelope register width (unsigned 6.4 fixed point)
//   ENV_FRAC    : fractional bits of the envelope format
//   step_toward : moves a gain value one LSB toward a target
// ---------------------------------------------------------------------------
package ts_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    RAMP    = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } phase_t;

  localparam int ENV_W    = 10;
  localparam int ENV_FRAC = 4;

  typedef logic [7:0] gain_t;

  localparam gain_t GAIN_UNITY = 8'd64;

  // The ramp and release phases walk the gain one LSB per tick; once the
  // target is reached the value is left alone so the FSM can see equality.
  function automatic gain_t step_toward(input gain_t cur, input gain_t target);
    gain_t result;
    result = cur;
    if (cur < target) begin
      result = cur + 8'd1;
    end else if (cur > target) begin
      result = cur - 8'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/ts_envelope_scheduler_envelope_pair.sv
// ---------------------------------------------------------------------------
// ts_envelope_pair
// Fast and slow leaky envelope followers of the input magnitude plus the
// transient compare between them.
//   clk, rst : system clock, asynchronous active-high reset
//   tick     : update strobe (already qualified by the design enable)
//   sample   : 6-bit unsigned input magnitude
//   trig     : fast envelope exceeds slow envelope plus threshold
// ---------------------------------------------------------------------------
module ts_envelope_pair
  import ts_pkg::*;
#(
  parameter int FAST_SHIFT = 2,
  parameter int SLOW_SHIFT = 6,
  parameter int THRESH     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic [5:0] sample,
  output logic       trig
);

  logic [ENV_W-1:0]        fast_env;
  logic [ENV_W-1:0]        slow_env;
  logic [ENV_W-1:0]        x;
  logic signed [ENV_W:0]   fast_diff;
  logic signed [ENV_W:0]   slow_diff;
  logic signed [ENV_W:0]   fast_step;
  logic signed [ENV_W:0]   slow_step;
  logic [ENV_W:0]          slow_thr;

  // The sample is placed on the integer part of the 6.4 envelope format.
  assign x = {sample, {ENV_FRAC{1'b0}}};

  // One extra bit holds the sign of the difference; the arithmetic shift
  // floors toward minus infinity so a decaying envelope always reaches zero.
  assign fast_diff = $signed({1'b0, x}) - $signed({1'b0, fast_env});
  assign slow_diff = $signed({1'b0, x}) - $signed({1'b0, slow_env});
  assign fast_step = fast_diff >>> FAST_SHIFT;
  assign slow_step = slow_diff >>> SLOW_SHIFT;

  // The compare uses the registered envelopes, so a step shows up as a
  // trigger one tick after the tick that first sampled it.
  assign slow_thr = {1'b0, slow_env} + ((ENV_W + 1)'(THRESH) << ENV_FRAC);
  assign trig     = {1'b0, fast_env} > slow_thr;

  // Leaky integrators. The updated value always lies between the old value
  // and x, so truncating the step back to the envelope width is exact.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fast_env <= '0;
      slow_env <= '0;
    end else if (tick) begin
      fast_env <= fast_env + ENV_W'(fast_step);
      slow_env <= slow_env + ENV_W'(slow_step);
    end
  end

endmodule

// File: rtl/ts_envelope_scheduler.sv
// ---------------------------------------------------------------------------
// ts_envelope_scheduler
// Control block for the transient shaper: sample-rate tick generation,
// envelope tracking and the attack/ramp/sustain/release gain schedule.
//   clk, rst    : system clock, asynchronous active-high reset
//   ena         : design enable; low parks the schedule in IDLE at unity
//   sample      : 6-bit unsigned magnitude, consumed on tick
//   attack_amt  : 1 boosts the attack, 0 cuts it (sampled on ATTACK entry)
//   sustain_amt : 1 boosts the sustain, 0 cuts it (used live)
//   tick        : one-clk sample strobe
//   gain        : Q2.6 gain coefficient for the shaper multiplier
//   phase       : current schedule state encoding
//   busy        : high whenever the schedule is not IDLE
// ---------------------------------------------------------------------------
module ts_envelope_scheduler
  import ts_pkg::*;
#(
  parameter int CLK_DIV     = 500,
  parameter int FAST_SHIFT  = 2,
  parameter int SLOW_SHIFT  = 6,
  parameter int THRESH      = 8,
  parameter int BOOST       = 32,
  parameter int ATTACK_LEN  = 96,
  parameter int SUSTAIN_LEN = 480
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [5:0] sample,
  input  logic       attack_amt,
  input  logic       sustain_amt,
  output logic       tick,
  output logic [7:0] gain,
  output logic [2:0] phase,
  output logic       busy
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int CNT_W = 16;

  logic [DIV_W-1:0] div_cnt;
  logic [CNT_W-1:0] cnt;
  phase_t           state;
  logic             trig;
  logic             env_tick;
  gain_t            atk_gain;
  gain_t            sus_gain;

  // A tick left over from the cycle that ena dropped must not move the
  // envelopes, so the update strobe is qualified here as well.
  assign env_tick = tick & ena;

  assign atk_gain = attack_amt  ? GAIN_UNITY + gain_t'(BOOST)
                                : GAIN_UNITY - gain_t'(BOOST);
  assign sus_gain = sustain_amt ? GAIN_UNITY + gain_t'(BOOST / 2)
                                : GAIN_UNITY - gain_t'(BOOST / 2);

  assign phase = state;

  // Sample-rate divider. The tick is registered and fires on the clk after
  // the counter wraps; disabling freezes the count and silences the tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      tick    <= 1'b0;
    end else if (!ena) begin
      tick    <= 1'b0;
    end else if (div_cnt == DIV_W'(CLK_DIV - 1)) begin
      div_cnt <= '0;
      tick    <= 1'b1;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
      tick    <= 1'b0;
    end
  end

  ts_envelope_pair #(
    .FAST_SHIFT (FAST_SHIFT),
    .SLOW_SHIFT (SLOW_SHIFT),
    .THRESH     (THRESH)
  ) u_env (
    .clk    (clk),
    .rst    (rst),
    .tick   (env_tick),
    .sample (sample),
    .trig   (trig)
  );

  // Gain schedule. Every transition happens on a tick; a retrigger in
  // SUSTAIN or RELEASE takes priority over count expiry or ramp completion.
  // busy is set on the way into ATTACK and cleared on the way into IDLE so
  // it always matches the registered phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      gain  <= GAIN_UNITY;
      cnt   <= '0;
      busy  <= 1'b0;
    end else if (!ena) begin
      state <= IDLE;
      gain  <= GAIN_UNITY;
      cnt   <= '0;
      busy  <= 1'b0;
    end else if (tick) begin
      case (state)
        IDLE: begin
          gain <= GAIN_UNITY;
          if (trig) begin
            state <= ATTACK;
            cnt   <= '0;
            gain  <= atk_gain;
            busy  <= 1'b1;
          end
        end
        ATTACK: begin
          if (cnt == CNT_W'(ATTACK_LEN - 1)) begin
            state <= RAMP;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RAMP: begin
          if (gain == sus_gain) begin
            state <= SUSTAIN;
            cnt   <= '0;
          end else begin
            gain <= step_toward(gain, sus_gain);
          end
        end
        SUSTAIN: begin
          if (trig) begin
            state <= ATTACK;
            cnt   <= '0;
            gain  <= atk_gain;
          end else begin
            gain <= sus_gain;
            if (cnt == CNT_W'(SUSTAIN_LEN - 1)) begin
              state <= RELEASE;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        RELEASE: begin
          if (trig) begin
            state <= ATTACK;
            cnt   <= '0;
            gain  <= atk_gain;
          end else if (gain == GAIN_UNITY) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            gain <= step_toward(gain, GAIN_UNITY);
          end
        end
        default: begin
          state <= IDLE;
          gain  <= GAIN_UNITY;
          cnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ts_envelope_scheduler.sv
// ---------------------------------------------------------------------------
// tb_ts_envelope_scheduler
// Self-checking bench for ts_envelope_scheduler with short schedule lengths.
// A behavioural model of the tick, envelopes and gain schedule is stepped on
// every clk and compared against the design outputs.
// ---------------------------------------------------------------------------
module tb_ts_envelope_scheduler;

  localparam int CLK_DIV     = 4;
  localparam int FAST_SHIFT  = 2;
  localparam int SLOW_SHIFT  = 6;
  localparam int THRESH      = 8;
  localparam int BOOST       = 32;
  localparam int ATTACK_LEN  = 4;
  localparam int SUSTAIN_LEN = 8;

  localparam int P_IDLE = 0, P_ATTACK = 1, P_RAMP = 2, P_SUSTAIN = 3, P_RELEASE = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ena = 1'b0;
  logic [5:0] sample = 6'd0;
  logic       attack_amt = 1'b0;
  logic       sustain_amt = 1'b0;
  logic       tick;
  logic [7:0] gain;
  logic [2:0] phase;
  logic       busy;

  int checks = 0;
  int failures = 0;

  // Reference model state
  int m_div, m_tick, m_fast, m_slow, m_phase, m_gain, m_cnt;

  ts_envelope_scheduler #(
    .CLK_DIV     (CLK_DIV),
    .FAST_SHIFT  (FAST_SHIFT),
    .SLOW_SHIFT  (SLOW_SHIFT),
    .THRESH      (THRESH),
    .BOOST       (BOOST),
    .ATTACK_LEN  (ATTACK_LEN),
    .SUSTAIN_LEN (SUSTAIN_LEN)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ena         (ena),
    .sample      (sample),
    .attack_amt  (attack_amt),
    .sustain_amt (sustain_amt),
    .tick        (tick),
    .gain        (gain),
    .phase       (phase),
    .busy        (busy)
  );

  // Free-running clock, 10 time units per period
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d at time %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic e, input logic [5:0] s, input logic a, input logic su);
    ena         = e;
    sample      = s;
    attack_amt  = a;
    sustain_amt = su;
  endtask

  // Floor division by a power of two, valid for negative values too
  function automatic int floorShift(input int v, input int s);
    int d;
    d = 1 << s;
    if (v >= 0) return v / d;
    return -((-v + d - 1) / d);
  endfunction

  function automatic int towards(input int cur, input int target);
    if (cur < target) return cur + 1;
    if (cur > target) return cur - 1;
    return cur;
  endfunction

  task automatic modelReset();
    m_div = 0; m_tick = 0; m_fast = 0; m_slow = 0;
    m_phase = P_IDLE; m_gain = 64; m_cnt = 0;
  endtask

  // One clk of the behavioural model, using the inputs held across the edge
  task automatic modelStep();
    int tick_now, trig_now, x, s_gain, a_gain;
    if (rst) begin
      modelReset();
      return;
    end
    tick_now = m_tick;
    trig_now = (m_fast > m_slow + THRESH * 16) ? 1 : 0;
    s_gain = sustain_amt ? 64 + BOOST / 2 : 64 - BOOST / 2;
    a_gain = attack_amt  ? 64 + BOOST     : 64 - BOOST;

    if (!ena) m_tick = 0;
    else if (m_div == CLK_DIV - 1) begin m_div = 0; m_tick = 1; end
    else begin m_div++; m_tick = 0; end

    if (ena && tick_now == 1) begin
      x = int'(sample) * 16;
      m_fast = m_fast + floorShift(x - m_fast, FAST_SHIFT);
      m_slow = m_slow + floorShift(x - m_slow, SLOW_SHIFT);
    end

    if (!ena) begin
      m_phase = P_IDLE; m_gain = 64; m_cnt = 0;
    end else if (tick_now == 1) begin
      if (m_phase == P_IDLE) begin
        if (trig_now == 1) begin m_phase = P_ATTACK; m_cnt = 0; m_gain = a_gain; end
      end else if (m_phase == P_ATTACK) begin
        m_cnt++;
        if (m_cnt == ATTACK_LEN) begin m_phase = P_RAMP; m_cnt = 0; end
      end else if (m_phase == P_RAMP) begin
        if (m_gain == s_gain) begin m_phase = P_SUSTAIN; m_cnt = 0; end
        else m_gain = towards(m_gain, s_gain);
      end else if (trig_now == 1) begin
        m_phase = P_ATTACK; m_cnt = 0; m_gain = a_gain;
      end else if (m_phase == P_SUSTAIN) begin
        m_gain = s_gain;
        m_cnt++;
        if (m_cnt == SUSTAIN_LEN) begin m_phase = P_RELEASE; m_cnt = 0; end
      end else begin
        if (m_gain == 64) m_phase = P_IDLE;
        else m_gain = towards(m_gain, 64);
      end
    end
  endtask

  task automatic checkAll();
    checkOutput("tick",  int'(tick),  m_tick);
    checkOutput("gain",  int'(gain),  m_gain);
    checkOutput("phase", int'(phase), m_phase);
    checkOutput("busy",  int'(busy),  (m_phase != P_IDLE) ? 1 : 0);
    checkOutput("fast_env", int'(dut.u_env.fast_env), m_fast);
    checkOutput("slow_env", int'(dut.u_env.slow_env), m_slow);
  endtask

  task automatic runCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      modelStep();
      @(negedge clk);
      checkAll();
    end
  endtask

  // Runs until the model reaches a phase (and gain, if target_gain >= 0)
  task automatic waitState(input int target_phase, input int target_gain,
                           input int budget, input string tag);
    int found;
    found = 0;
    for (int i = 0; i < budget; i++) begin
      if (m_phase == target_phase && (target_gain < 0 || m_gain == target_gain)) begin
        found = 1;
        break;
      end
      runCycles(1);
    end
    checkOutput(tag, found, 1);
  endtask

  // One-tick 0 -> 63 -> 0 pulse: exactly one tick falls inside CLK_DIV clks
  task automatic pulse();
    applyStimulus(ena, 6'd63, attack_amt, sustain_amt);
    runCycles(CLK_DIV);
    applyStimulus(ena, 6'd0, attack_amt, sustain_amt);
  endtask

  initial begin
    int tcount;
    int snap_fast, snap_slow;
    int r;

    // Async reset asserted between clk edges
    applyStimulus(1'b0, 6'd0, 1'b1, 1'b0);
    #3 rst = 1'b1;
    #1;
    modelReset();
    checkOutput("rst_gain", int'(gain), 64);
    checkOutput("rst_phase", int'(phase), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_tick", int'(tick), 0);
    runCycles(3);
    rst = 1'b0;

    // Idle with sample = 0: tick every CLK_DIV clks, unity gain
    applyStimulus(1'b1, 6'd0, 1'b1, 1'b0);
    tcount = 0;
    for (int i = 0; i < 4 * CLK_DIV; i++) begin
      runCycles(1);
      tcount += int'(tick);
    end
    checkOutput("idle_tick_count", tcount, 4);

    // Step detection and full schedule
    applyStimulus(1'b1, 6'd63, 1'b1, 1'b0);
    runCycles(CLK_DIV);
    checkOutput("step_fast", int'(dut.u_env.fast_env), 252);
    checkOutput("step_slow", int'(dut.u_env.slow_env), 15);
    applyStimulus(1'b1, 6'd0, 1'b1, 1'b0);
    runCycles(CLK_DIV);
    checkOutput("trig_phase", int'(phase), 1);
    checkOutput("trig_gain", int'(gain), 96);
    checkOutput("trig_busy", int'(busy), 1);
    waitState(P_RAMP, -1, 100, "wait_ramp");
    checkOutput("ramp_entry_gain", int'(gain), 96);
    waitState(P_SUSTAIN, -1, 400, "wait_sustain");
    checkOutput("sustain_gain", int'(gain), 48);
    waitState(P_RELEASE, -1, 100, "wait_release");
    waitState(P_IDLE, -1, 200, "wait_idle");
    checkOutput("idle_gain", int'(gain), 64);
    checkOutput("idle_busy", int'(busy), 0);

    // Retrigger during RELEASE at gain 56, then a step inside ATTACK
    runCycles(40);
    pulse();
    waitState(P_RELEASE, 56, 600, "wait_release56");
    pulse();
    runCycles(CLK_DIV);
    checkOutput("retrig_phase", int'(phase), 1);
    checkOutput("retrig_gain", int'(gain), 96);
    pulse();
    runCycles(CLK_DIV);
    checkOutput("attack_hold_phase", int'(phase), 1);
    checkOutput("attack_hold_gain", int'(gain), 96);

    // Enable drop during SUSTAIN
    waitState(P_SUSTAIN, -1, 400, "wait_sustain2");
    applyStimulus(1'b0, 6'd0, 1'b1, 1'b0);
    runCycles(1);
    checkOutput("ena_phase", int'(phase), 0);
    checkOutput("ena_gain", int'(gain), 64);
    snap_fast = m_fast;
    snap_slow = m_slow;
    runCycles(10);
    applyStimulus(1'b1, 6'd0, 1'b1, 1'b0);
    runCycles(1);
    checkOutput("ena_hold_fast", int'(dut.u_env.fast_env), snap_fast);
    checkOutput("ena_hold_slow", int'(dut.u_env.slow_env), snap_slow);
    checkOutput("ena_resume_phase", int'(phase), 0);

    // Async reset in the middle of RAMP
    runCycles(40);
    pulse();
    waitState(P_RAMP, -1, 100, "wait_ramp2");
    runCycles(3);
    #2 rst = 1'b1;
    #1;
    modelReset();
    checkOutput("async_gain", int'(gain), 64);
    checkOutput("async_phase", int'(phase), 0);
    checkOutput("async_busy", int'(busy), 0);
    runCycles(2);
    rst = 1'b0;

    // Randomized traffic against the model
    applyStimulus(1'b1, 6'd0, 1'b1, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 3) sample = 6'($urandom_range(40, 63));
      else if (r < 40) sample = 6'd0;
      else if (r < 45) sample = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 49) == 0) attack_amt = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 49) == 0) sustain_amt = 1'($urandom_range(0, 1));
      ena = ($urandom_range(0, 299) != 0);
      runCycles(1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
